// File: rtl/stream_demux_n.sv
// Registered 1-to-NUM_CH stream demultiplexer with valid/ready on every port.
// Each channel owns a one-entry output slot; routing is by s_sel or round-robin.
module stream_demux_n #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned RR_MODE = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [DATA_W-1:0]        s_data,
   input  logic [$clog2(NUM_CH)-1:0] s_sel,
   output logic [NUM_CH-1:0]        m_valid,
   input  logic [NUM_CH-1:0]        m_ready,
   output logic [NUM_CH*DATA_W-1:0] m_data,
   output logic                     drop,
   output logic [7:0]               drop_cnt
);

   localparam int unsigned SEL_W = $clog2(NUM_CH);

   logic [SEL_W-1:0]  rr_ptr;
   logic [SEL_W-1:0]  tgt;
   logic              tgt_ok;
   logic              accept;
   logic              drop_next;
   logic [NUM_CH-1:0] slot_free;
   logic [NUM_CH-1:0] fill;

   // Target selection and per-slot availability; an out-of-range target is
   // always ready so the word is swallowed instead of stalling the producer.
   always_comb begin
      tgt       = (RR_MODE != 0) ? rr_ptr : s_sel;
      tgt_ok    = 32'(tgt) < 32'(NUM_CH);
      slot_free = ~m_valid | m_ready;
      s_ready   = 1'b1;
      fill      = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (tgt == SEL_W'(k)) begin
            s_ready = slot_free[k];
            fill[k] = s_valid & slot_free[k];
         end
      end
      accept    = s_valid & s_ready;
      drop_next = accept & ~tgt_ok;
   end

   // Output slots: a refill wins over a drain in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= '0;
         m_data  <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (fill[k]) begin
               m_valid[k]                    <= 1'b1;
               m_data[k*DATA_W +: DATA_W]    <= s_data;
            end else if (m_ready[k]) begin
               m_valid[k]                    <= 1'b0;
            end
         end
      end
   end

   // Round-robin pointer only moves on an accept, so a busy target blocks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (accept) begin
         rr_ptr <= (rr_ptr == SEL_W'(NUM_CH - 1)) ? '0 : rr_ptr + SEL_W'(1);
      end
   end

   // Discard reporting: one-cycle pulse and a saturating counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop     <= 1'b0;
         drop_cnt <= '0;
      end else begin
         drop <= drop_next;
         if (drop_next && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_stream_demux_n.sv
// Bench for stream_demux_n: three instances (4ch select, 3ch round-robin,
// 3ch select with an illegal code) checked against per-channel word queues.
module tb_stream_demux_n;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]       in_valid;
   logic [2:0][7:0]  in_data;
   logic [2:0][1:0]  in_sel;
   logic [2:0][3:0]  in_mready;

   logic [2:0]       out_ready;
   logic [2:0]       out_drop;
   logic [2:0][3:0]  out_mvalid;
   logic [2:0][31:0] out_mdata;
   logic [2:0][7:0]  out_cnt;

   logic        a_ready, b_ready, c_ready, a_drop, b_drop, c_drop;
   logic [3:0]  a_mvalid;
   logic [2:0]  b_mvalid, c_mvalid;
   logic [31:0] a_mdata;
   logic [23:0] b_mdata, c_mdata;
   logic [7:0]  a_cnt, b_cnt, c_cnt;

   stream_demux_n #(.DATA_W(8), .NUM_CH(4), .RR_MODE(0)) u_a (
      .clk(clk), .rst(rst), .s_valid(in_valid[0]), .s_ready(a_ready),
      .s_data(in_data[0]), .s_sel(in_sel[0]), .m_valid(a_mvalid),
      .m_ready(in_mready[0]), .m_data(a_mdata), .drop(a_drop), .drop_cnt(a_cnt));

   stream_demux_n #(.DATA_W(8), .NUM_CH(3), .RR_MODE(1)) u_b (
      .clk(clk), .rst(rst), .s_valid(in_valid[1]), .s_ready(b_ready),
      .s_data(in_data[1]), .s_sel(in_sel[1]), .m_valid(b_mvalid),
      .m_ready(in_mready[1][2:0]), .m_data(b_mdata), .drop(b_drop), .drop_cnt(b_cnt));

   stream_demux_n #(.DATA_W(8), .NUM_CH(3), .RR_MODE(0)) u_c (
      .clk(clk), .rst(rst), .s_valid(in_valid[2]), .s_ready(c_ready),
      .s_data(in_data[2]), .s_sel(in_sel[2]), .m_valid(c_mvalid),
      .m_ready(in_mready[2][2:0]), .m_data(c_mdata), .drop(c_drop), .drop_cnt(c_cnt));

   assign out_ready  = {c_ready, b_ready, a_ready};
   assign out_drop   = {c_drop, b_drop, a_drop};
   assign out_mvalid = {{1'b0, c_mvalid}, {1'b0, b_mvalid}, a_mvalid};
   assign out_mdata  = {{8'h00, c_mdata}, {8'h00, b_mdata}, a_mdata};
   assign out_cnt    = {c_cnt, b_cnt, a_cnt};

   // Reference model: each channel is a queue of words not yet taken by its consumer.
   logic [7:0] q [3][4][$];
   int   rr [3];
   int   dcnt [3];
   logic exp_drop [3];
   logic stall [3];
   int   checks;
   int   errors;

   function automatic int nch(input int i);
      return (i == 0) ? 4 : 3;
   endfunction

   function automatic int tgt_of(input int i);
      return (i == 1) ? rr[i] : int'(in_sel[i]);
   endfunction

   task automatic chk(input string tag, input int i, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s inst%0d observed %0h expected %0h", tag, i, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k < 4; k++) q[i][k].delete();
         rr[i] = 0;
         dcnt[i] = 0;
         exp_drop[i] = 1'b0;
         stall[i] = 1'b0;
      end
   endtask

   // One clock: check every instance mid-cycle, advance the model, cross the edge.
   task automatic tick();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         int t;
         logic inr, rdy;
         logic [3:0] emv;
         t   = tgt_of(i);
         inr = t < nch(i);
         rdy = !inr || q[i][t].size() == 0 || in_mready[i][t];
         emv = '0;
         for (int k = 0; k < nch(i); k++) emv[k] = q[i][k].size() != 0;
         chk("s_ready", i, 32'(out_ready[i]), 32'(rdy));
         chk("m_valid", i, 32'(out_mvalid[i]), 32'(emv));
         for (int k = 0; k < nch(i); k++)
            if (q[i][k].size() != 0)
               chk("m_data", i, 32'(out_mdata[i][k*8 +: 8]), 32'(q[i][k][0]));
         chk("drop", i, 32'(out_drop[i]), 32'(exp_drop[i]));
         chk("drop_cnt", i, 32'(out_cnt[i]), 32'(dcnt[i]));
         for (int k = 0; k < nch(i); k++)
            if (q[i][k].size() != 0 && in_mready[i][k]) void'(q[i][k].pop_front());
         exp_drop[i] = 1'b0;
         if (in_valid[i] && rdy) begin
            if (inr) begin
               q[i][t].push_back(in_data[i]);
               rr[i] = (rr[i] + 1) % nch(i);
            end else begin
               exp_drop[i] = 1'b1;
               if (dcnt[i] < 255) dcnt[i]++;
            end
         end
         stall[i] = in_valid[i] && !rdy;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      in_valid = '0;
      in_data = '0;
      in_sel = '0;
      in_mready = '1;
      model_reset();
      #1 rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_m_valid", i, 32'(out_mvalid[i]), 32'h0);
         chk("rst_m_data", i, out_mdata[i], 32'h0);
         chk("rst_drop", i, 32'(out_drop[i]), 32'h0);
         chk("rst_drop_cnt", i, 32'(out_cnt[i]), 32'h0);
      end
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // Single word to channel 2 with everyone ready.
      in_sel[0] = 2'd2; in_data[0] = 8'hA1; in_valid[0] = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      chk("sel2_valid", 0, 32'(out_mvalid[0]), 32'b0100);
      chk("sel2_data", 0, 32'(out_mdata[0][23:16]), 32'hA1);
      chk("sel2_ready", 0, 32'(out_ready[0]), 32'h1);
      tick();

      // Backpressure on channel 1, then drain-and-refill at one edge.
      in_mready[0] = 4'b1101;
      in_sel[0] = 2'd1; in_data[0] = 8'h11; in_valid[0] = 1'b1;
      tick();
      in_data[0] = 8'h22;
      #1;
      chk("bp_ready_low", 0, 32'(out_ready[0]), 32'h0);
      tick();
      chk("bp_hold", 0, 32'(out_mdata[0][15:8]), 32'h11);
      in_mready[0] = 4'b1111;
      #1;
      chk("bp_ready_high", 0, 32'(out_ready[0]), 32'h1);
      tick();
      in_valid[0] = 1'b0;
      chk("bp_refill", 0, 32'(out_mdata[0][15:8]), 32'h22);
      tick();

      // Stalled channel 0 does not block full-rate traffic into channel 3.
      in_mready[0] = 4'b1110;
      in_sel[0] = 2'd0; in_data[0] = 8'h55; in_valid[0] = 1'b1;
      tick();
      for (int n = 0; n < 8; n++) begin
         in_sel[0] = 2'd3; in_data[0] = 8'(8'h30 + n);
         tick();
         chk("ind_ch3", 0, 32'(out_mdata[0][31:24]), 32'(8'h30 + n));
         chk("ind_ch0", 0, 32'(out_mdata[0][7:0]), 32'h55);
      end
      in_valid[0] = 1'b0;
      in_mready[0] = 4'b1111;
      tick();
      tick();

      // Round-robin over three channels.
      for (int n = 1; n <= 6; n++) begin
         in_data[1] = 8'(n); in_valid[1] = 1'b1;
         tick();
         chk("rr_valid", 1, 32'(out_mvalid[1]), 32'(1 << ((n - 1) % 3)));
         chk("rr_data", 1, 32'(out_mdata[1][((n - 1) % 3)*8 +: 8]), 32'(n));
      end
      in_valid[1] = 1'b0;
      tick();

      // Out-of-range select is swallowed and counted.
      in_sel[2] = 2'd3; in_valid[2] = 1'b1;
      for (int n = 0; n < 3; n++) begin
         in_data[2] = 8'(n);
         tick();
      end
      in_valid[2] = 1'b0;
      chk("drop_pulse", 2, 32'(out_drop[2]), 32'h1);
      chk("drop_three", 2, 32'(out_cnt[2]), 32'h3);
      chk("drop_no_valid", 2, 32'(out_mvalid[2]), 32'h0);
      tick();
      chk("drop_end", 2, 32'(out_drop[2]), 32'h0);
      in_valid[2] = 1'b1;
      for (int n = 0; n < 260; n++) tick();
      in_valid[2] = 1'b0;
      tick();
      chk("drop_sat", 2, 32'(out_cnt[2]), 32'hFF);

      // Reset while channels 0 and 2 hold data.
      in_mready[0] = 4'b1010;
      in_sel[0] = 2'd0; in_data[0] = 8'h5A; in_valid[0] = 1'b1;
      tick();
      in_sel[0] = 2'd2; in_data[0] = 8'hA5;
      tick();
      in_valid[0] = 1'b0;
      chk("pre_rst_valid", 0, 32'(out_mvalid[0]), 32'b0101);
      rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("mid_rst_valid", i, 32'(out_mvalid[i]), 32'h0);
         chk("mid_rst_data", i, out_mdata[i], 32'h0);
      end
      model_reset();
      #2 rst = 1'b0;
      in_mready[0] = 4'b1111;
      in_sel[0] = 2'd0; in_data[0] = 8'h77; in_valid[0] = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      chk("post_rst_valid", 0, 32'(out_mvalid[0]), 32'b0001);
      chk("post_rst_data", 0, 32'(out_mdata[0][7:0]), 32'h77);
      tick();

      // Random traffic on all instances; stalled words are held.
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < 3; i++) begin
            if (!stall[i]) begin
               in_valid[i] = ($urandom % 4) != 0;
               in_data[i]  = 8'($urandom);
               in_sel[i]   = 2'($urandom);
            end
            in_mready[i] = 4'($urandom | $urandom);
         end
         tick();
      end
      in_valid = '0;
      in_mready = '1;
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
